// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state
// encoding and default widths/timeout used by ifetch_unit and its timer.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_HOLD = 2'd2
    } if_state_t;

    localparam int IF_ADDR_W  = 16;
    localparam int IF_DATA_W  = 16;
    localparam int IF_TIMEOUT = 8;

endpackage

// File: rtl/ifetch_timer.sv
// Clearable up-counter that measures how long a memory request has been
// outstanding; tc flags the last permitted wait cycle (count == TIMEOUT-1).
module ifetch_timer
    import ifetch_pkg::*;
#(
    parameter  int TIMEOUT = IF_TIMEOUT,
    localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count;

    // Count while enabled; clear has priority so a new request starts at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: reads imem at pcIn with a level req/ack
// handshake, holds the instruction for decode, and pulses pcWrite back to
// pc_block once decode accepts it. Flush and a bounded wait abort a fetch.
//
// Handshake: imemReq is a level that stays high with imemAddr stable until
// the cycle imemAck=1 is sampled (or flush/timeout aborts); imemAck outside
// REQ is ignored. Towards decode, instrValid stays high with instr/instrPc
// stable until decodeReady=1 is sampled (or flush).
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int ADDR_W  = IF_ADDR_W,
    parameter int DATA_W  = IF_DATA_W,
    parameter int TIMEOUT = IF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pcIn,
    input  logic              fetchEn,
    input  logic              flush,
    input  logic              decodeReady,
    input  logic              imemAck,
    input  logic [DATA_W-1:0] imemData,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instrPc,
    output logic              instrValid,
    output logic              pcWrite,
    output logic              fetchErr,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    if_state_t         state, state_n;
    logic              req_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] instr_n;
    logic [ADDR_W-1:0] instr_pc_n;
    logic              valid_n;
    logic              pc_write_n;
    logic              fetch_err_n;
    logic              tmr_tc;

    // Wait counter runs only while a request is outstanding and sits at
    // zero otherwise, so every request starts from a fresh count.
    ifetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .clr   (state != IF_REQ),
        .en    (state == IF_REQ),
        .tc    (tmr_tc)
    );

    // Next-state and next-output decode; flush dominates ack, accept and timeout.
    always_comb begin
        state_n     = state;
        req_n       = imemReq;
        addr_n      = imemAddr;
        instr_n     = instr;
        instr_pc_n  = instrPc;
        valid_n     = instrValid;
        pc_write_n  = 1'b0;
        fetch_err_n = 1'b0;
        case (state)
            IF_IDLE: begin
                // pcWrite high means pc_block has not advanced yet: wait a cycle.
                if (fetchEn && !flush && !pcWrite) begin
                    state_n = IF_REQ;
                    req_n   = 1'b1;
                    addr_n  = pcIn;
                end
            end
            IF_REQ: begin
                if (flush) begin
                    state_n = IF_IDLE;
                    req_n   = 1'b0;
                end else if (imemAck) begin
                    state_n    = IF_HOLD;
                    req_n      = 1'b0;
                    instr_n    = imemData;
                    instr_pc_n = imemAddr;
                    valid_n    = 1'b1;
                end else if (tmr_tc) begin
                    state_n     = IF_IDLE;
                    req_n       = 1'b0;
                    fetch_err_n = 1'b1;
                end
            end
            IF_HOLD: begin
                if (flush) begin
                    state_n = IF_IDLE;
                    valid_n = 1'b0;
                end else if (decodeReady) begin
                    state_n    = IF_IDLE;
                    valid_n    = 1'b0;
                    pc_write_n = 1'b1;
                end
            end
            default: begin
                state_n = IF_IDLE;
                req_n   = 1'b0;
                valid_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IF_IDLE;
            imemReq    <= 1'b0;
            imemAddr   <= '0;
            instr      <= '0;
            instrPc    <= '0;
            instrValid <= 1'b0;
            pcWrite    <= 1'b0;
            fetchErr   <= 1'b0;
        end else begin
            state      <= state_n;
            imemReq    <= req_n;
            imemAddr   <= addr_n;
            instr      <= instr_n;
            instrPc    <= instr_pc_n;
            instrValid <= valid_n;
            pcWrite    <= pc_write_n;
            fetchErr   <= fetch_err_n;
        end
    end

    assign busy      = (state != IF_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: normal fetch, decode stall, flush in REQ
// and HOLD, timeout abort and last-cycle ack, back-to-back fetch, and
// asynchronous reset mid-request.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] pcIn;
    logic        fetchEn;
    logic        flush;
    logic        decodeReady;
    logic        imemAck;
    logic [15:0] imemData;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic [15:0] instr;
    logic [15:0] instrPc;
    logic        instrValid;
    logic        pcWrite;
    logic        fetchErr;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // expected {instrPc, instr} for each fetch that should complete
    logic [31:0] exp_q[$];

    ifetch_unit #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pcIn        (pcIn),
        .fetchEn     (fetchEn),
        .flush       (flush),
        .decodeReady (decodeReady),
        .imemAck     (imemAck),
        .imemData    (imemData),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .instr       (instr),
        .instrPc     (instrPc),
        .instrValid  (instrValid),
        .pcWrite     (pcWrite),
        .fetchErr    (fetchErr),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start_fetch(input logic [15:0] pc);
        pcIn    = pc;
        fetchEn = 1'b1;
        tick();
        fetchEn = 1'b0;
    endtask

    task automatic ack_with(input logic [15:0] data, input logic [15:0] pc);
        imemAck  = 1'b1;
        imemData = data;
        exp_q.push_back({pc, data});
        tick();
        imemAck = 1'b0;
    endtask

    // scoreboard: held instruction must match the oldest expected fetch
    task automatic check_held(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(instrValid), 32'd1);
            chk({tag, "_instr"}, 32'(instr), 32'(e[15:0]));
            chk({tag, "_pc"}, 32'(instrPc), 32'(e[31:16]));
        end
    endtask

    initial begin
        reset       = 1'b1;
        pcIn        = '0;
        fetchEn     = 1'b0;
        flush       = 1'b0;
        decodeReady = 1'b0;
        imemAck     = 1'b0;
        imemData    = '0;
        tick(2);
        chk("rst_req", 32'(imemReq), 32'd0);
        chk("rst_addr", 32'(imemAddr), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_valid", 32'(instrValid), 32'd0);
        chk("rst_pcw", 32'(pcWrite), 32'd0);
        chk("rst_err", 32'(fetchErr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IF_IDLE));
        reset = 1'b0;
        tick();

        // normal fetch, ack on the second request cycle
        start_fetch(16'h0002);
        chk("nf_req", 32'(imemReq), 32'd1);
        chk("nf_addr", 32'(imemAddr), 32'h0002);
        chk("nf_state", 32'(dbg_state), 32'(IF_REQ));
        tick();
        chk("nf_req_hold", 32'(imemReq), 32'd1);
        ack_with(16'hA5C3, 16'h0002);
        chk("nf_req_drop", 32'(imemReq), 32'd0);
        check_held("nf");
        decodeReady = 1'b1;
        tick();
        decodeReady = 1'b0;
        chk("nf_pcw", 32'(pcWrite), 32'd1);
        chk("nf_valid_drop", 32'(instrValid), 32'd0);
        chk("nf_idle", 32'(dbg_state), 32'(IF_IDLE));
        tick();
        chk("nf_pcw_once", 32'(pcWrite), 32'd0);

        // decode stall; fetchEn and a stray ack during HOLD are ignored
        start_fetch(16'h0006);
        ack_with(16'h5A3C, 16'h0006);
        check_held("st");
        fetchEn  = 1'b1;
        imemAck  = 1'b1;
        imemData = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("st_instr", 32'(instr), 32'h5A3C);
            chk("st_valid", 32'(instrValid), 32'd1);
            chk("st_pcw", 32'(pcWrite), 32'd0);
            chk("st_req", 32'(imemReq), 32'd0);
        end
        fetchEn     = 1'b0;
        imemAck     = 1'b0;
        decodeReady = 1'b1;
        tick();
        decodeReady = 1'b0;
        chk("st_pcw", 32'(pcWrite), 32'd1);
        tick();
        chk("st_pcw_once", 32'(pcWrite), 32'd0);

        // flush in REQ together with ack
        start_fetch(16'h0008);
        flush    = 1'b1;
        imemAck  = 1'b1;
        imemData = 16'h1234;
        tick();
        flush   = 1'b0;
        imemAck = 1'b0;
        chk("fr_req", 32'(imemReq), 32'd0);
        chk("fr_valid", 32'(instrValid), 32'd0);
        chk("fr_busy", 32'(busy), 32'd0);
        chk("fr_pcw", 32'(pcWrite), 32'd0);
        tick();
        chk("fr_pcw2", 32'(pcWrite), 32'd0);
        chk("fr_req2", 32'(imemReq), 32'd0);

        // flush in HOLD beats a simultaneous accept
        start_fetch(16'h000A);
        ack_with(16'h0BEE, 16'h000A);
        check_held("fh");
        flush       = 1'b1;
        decodeReady = 1'b1;
        tick();
        flush       = 1'b0;
        decodeReady = 1'b0;
        chk("fh_valid", 32'(instrValid), 32'd0);
        chk("fh_pcw", 32'(pcWrite), 32'd0);
        chk("fh_state", 32'(dbg_state), 32'(IF_IDLE));
        tick();
        chk("fh_pcw2", 32'(pcWrite), 32'd0);

        // timeout: request held exactly 8 cycles, then one fetchErr pulse
        start_fetch(16'h0020);
        chk("to_req1", 32'(imemReq), 32'd1);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("to_req", 32'(imemReq), 32'd1);
            chk("to_err_early", 32'(fetchErr), 32'd0);
        end
        tick();
        chk("to_req_drop", 32'(imemReq), 32'd0);
        chk("to_err", 32'(fetchErr), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_pcw", 32'(pcWrite), 32'd0);
        tick();
        chk("to_err_once", 32'(fetchErr), 32'd0);

        // ack on the eighth request cycle wins over timeout
        start_fetch(16'h0030);
        tick(7);
        chk("ta_req", 32'(imemReq), 32'd1);
        ack_with(16'hC0DE, 16'h0030);
        chk("ta_err", 32'(fetchErr), 32'd0);
        check_held("ta");
        decodeReady = 1'b1;
        tick();
        decodeReady = 1'b0;
        chk("ta_pcw", 32'(pcWrite), 32'd1);
        tick();

        // back-to-back: fetchEn held across accept, pc_block model updates PC
        pcIn    = 16'h0002;
        fetchEn = 1'b1;
        tick();
        chk("bb_addr1", 32'(imemAddr), 32'h0002);
        ack_with(16'h1111, 16'h0002);
        check_held("bb");
        decodeReady = 1'b1;
        tick();
        decodeReady = 1'b0;
        chk("bb_pcw", 32'(pcWrite), 32'd1);
        chk("bb_noreq_a", 32'(imemReq), 32'd0);
        tick();
        chk("bb_noreq_b", 32'(imemReq), 32'd0);
        chk("bb_pcw_once", 32'(pcWrite), 32'd0);
        pcIn = 16'h0004;
        tick();
        fetchEn = 1'b0;
        chk("bb_req2", 32'(imemReq), 32'd1);
        chk("bb_addr2", 32'(imemAddr), 32'h0004);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // asynchronous reset mid-request, then a late ack
        start_fetch(16'h0010);
        chk("ar_req_pre", 32'(imemReq), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_req", 32'(imemReq), 32'd0);
        chk("ar_valid", 32'(instrValid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        imemAck  = 1'b1;
        imemData = 16'h7777;
        tick();
        reset = 1'b0;
        tick();
        imemAck = 1'b0;
        chk("ar_late_valid", 32'(instrValid), 32'd0);
        chk("ar_late_instr", 32'(instr), 32'd0);
        chk("ar_late_state", 32'(dbg_state), 32'(IF_IDLE));
        chk("ar_q_empty", 32'(exp_q.size()), 32'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch stage directly downstream of pc_block.
- Takes pcOut as the fetch address and performs a req/ack read of instruction memory.
- Holds the returned 16-bit instruction and its PC for decode until accepted.
- On acceptance, pulses pcWrite back to pc_block so the PC advances.
- Supports flush (branch redirect) and a bounded memory-wait timeout.

Parameters:
ADDR_W, 16, width of PC and instruction-memory address
DATA_W, 16, instruction width
TIMEOUT, 8, max cycles imemReq may wait for imemAck before abort (must be ≥2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pcIn  input  ADDR_W  current PC (pc_block pcOut)
fetchEn  input  1  control requests a fetch
flush  input  1  abandon in-flight/held instruction (branch redirect)
decodeReady  input  1  decode accepts the held instruction this cycle
imemAck  input  1  memory returns data this cycle
imemData  input  DATA_W  memory read data, valid when imemAck=1
imemReq  output  1  memory read request (level)
imemAddr  output  ADDR_W  memory address, stable while imemReq=1
instr  output  DATA_W  held instruction
instrPc  output  ADDR_W  address instr was fetched from
instrValid  output  1  instr/instrPc valid for decode
pcWrite  output  1  one-cycle pulse to pc_block: advance PC
fetchErr  output  1  one-cycle pulse: timeout abort
busy  output  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-high, using the codebase's clock and reset port names.
  - On reset, all outputs and state clear: state=IDLE, imemReq=0, imemAddr=0, instr=0, instrPc=0, instrValid=0, pcWrite=0, fetchErr=0, timeout count=0.
  - Reset mid-fetch drops imemReq immediately; a late imemAck is ignored.
- All outputs are registered. FSM has states IDLE, REQ, HOLD.
- IDLE:
  - If fetchEn=1, flush=0 and pcWrite=0: imemAddr<=pcIn, imemReq<=1, cnt<=0, go to REQ.
  - A fetch is never started in the cycle pcWrite is high, because pc_block has not yet updated.
- REQ: imemReq and imemAddr are held constant.
  - flush=1 has priority: imemReq<=0, go to IDLE. An imemAck in the same cycle is discarded.
  - Else imemAck=1: instr<=imemData, instrPc<=imemAddr, instrValid<=1, imemReq<=0, go to HOLD.
  - Else if cnt==TIMEOUT-1: imemReq<=0, fetchErr<=1 for one cycle, go to IDLE.
  - Else cnt<=cnt+1.
- HOLD: instrValid=1; instr and instrPc are stable.
  - flush=1 has priority: instrValid<=0, no pcWrite, go to IDLE.
  - Else decodeReady=1: instrValid<=0, pcWrite<=1 for exactly one cycle, go to IDLE.
  - Else stay in HOLD.
- Latency:
  - fetchEn sampled at edge N gives imemReq=1 after edge N.
  - imemAck at edge M gives instrValid=1 after edge M.
  - Accept at edge A gives pcWrite=1 in cycle A+1.
  - Earliest next imemReq follows edge A+2.
- Simultaneous events:
  - flush beats ack, accept and timeout.
  - ack beats timeout on the final count cycle.
  - fetchEn is ignored outside IDLE.
- imemAck outside REQ is ignored. fetchErr and pcWrite are never high in the same cycle.
- imemAddr wraps naturally; no arithmetic is performed here, because PC increment stays in pc_block.

Decomposition:
- Shared CPU package holds:
  - state encoding constants IF_IDLE=2'd0, IF_REQ=2'd1, IF_HOLD=2'd2;
  - ADDR_W/DATA_W defaults (16);
  - TIMEOUT default.
- One natural sub-module: ifetch_timer, a clearable up-counter with terminal-count flag, width $clog2(TIMEOUT). The FSM and output registers stay in ifetch_unit.

Test Plan:
- Reset state: assert reset mid-REQ (pcIn=0x0010) → within the same cycle imemReq=0, instrValid=0, busy=0; a later imemAck is ignored.
- Normal fetch: pcIn=0x0002, fetchEn=1, memory acks after 2 cycles with 0xA5C3 → imemAddr=0x0002, instr=0xA5C3, instrPc=0x0002, instrValid=1; with decodeReady=1 → exactly one pcWrite pulse, then IDLE.
- Decode stall: hold decodeReady=0 for 5 cycles after valid → instr stays stable, instrValid=1, pcWrite=0 throughout; release → single pcWrite.
- Flush: flush in REQ together with imemAck (data 0x1234) → instrValid stays 0, imemReq drops, no pcWrite. Flush in HOLD → instrValid drops, no pcWrite.
- Timeout: TIMEOUT=8, never ack → imemReq high exactly 8 cycles, fetchErr pulses 1 cycle, returns to IDLE. Ack on the 8th cycle → valid fetch, fetchErr=0.
- Back-to-back: fetchEn held high across accept → no new imemReq while pcWrite=1; next fetch uses the updated pcIn (0x0002→0x0004).
